// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: takes a word on a valid/ready handshake and
// streams it out one bit per clock, framed by dout_valid and last.
module piso_shift_tx #(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] Din,
    output logic             Dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             handshake;

    // Ready opens on the final bit so the next word can follow without a gap cycle.
    assign load_ready = clr && ((state == IDLE) || (cnt == LAST_CNT));
    assign handshake  = load_valid && load_ready;
    assign cnt_next   = cnt + CW'(1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            Dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
        end else if (handshake) begin
            state      <= SHIFT;
            cnt        <= '0;
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            last       <= (WIDTH == 1);
            // The first bit goes straight to Dout; shreg keeps the remaining bits.
            if (LSB_FIRST) begin
                Dout  <= Din[0];
                shreg <= Din >> 1;
            end else begin
                Dout  <= Din[WIDTH-1];
                shreg <= Din << 1;
            end
        end else if (state == SHIFT) begin
            if (cnt == LAST_CNT) begin
                state      <= IDLE;
                cnt        <= '0;
                Dout       <= IDLE_LEVEL;
                dout_valid <= 1'b0;
                last       <= 1'b0;
                busy       <= 1'b0;
            end else begin
                cnt  <= cnt_next;
                last <= (cnt_next == LAST_CNT);
                if (LSB_FIRST) begin
                    Dout  <= shreg[0];
                    shreg <= shreg >> 1;
                end else begin
                    Dout  <= shreg[WIDTH-1];
                    shreg <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: a vector table for the LSB-first build plus
// hand sequences for reset abort, loopback, MSB-first and single-bit words.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic       lv;
    logic [3:0] din;
    logic       ready, dout, dvalid, dlast, dbusy;

    logic       m_lv;
    logic [3:0] m_din;
    logic       m_ready, m_dout, m_valid, m_last, m_busy;

    logic       w_lv;
    logic [0:0] w_din;
    logic       w_ready, w_dout, w_valid, w_last, w_busy;

    logic [3:0] q;
    logic       rxClear;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .clr(clr), .load_valid(lv), .load_ready(ready), .Din(din),
        .Dout(dout), .dout_valid(dvalid), .last(dlast), .busy(dbusy)
    );

    piso_shift_tx #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
        .clk(clk), .clr(clr), .load_valid(m_lv), .load_ready(m_ready), .Din(m_din),
        .Dout(m_dout), .dout_valid(m_valid), .last(m_last), .busy(m_busy)
    );

    piso_shift_tx #(.WIDTH(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
        .clk(clk), .clr(clr), .load_valid(w_lv), .load_ready(w_ready), .Din(w_din),
        .Dout(w_dout), .dout_valid(w_valid), .last(w_last), .busy(w_busy)
    );

    // Right-shift receiver fed by the LSB-first transmitter.
    assign rxClear = ~clr;
    always_ff @(posedge clk or posedge rxClear) begin
        if (rxClear) q <= 4'b0000;
        else         q <= {dout, q[3:1]};
    end

    typedef struct {
        logic       clr;
        logic       lv;
        logic [3:0] din;
        logic       ready;
        logic       dout;
        logic       valid;
        logic       last;
    } vec_t;

    vec_t vecs[25];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic v, input logic [3:0] d);
        clr = c;
        lv  = v;
        din = d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp3;
        logic [3:0] exp8;
        logic [2:0] w1bits;

        // {clr, load_valid, Din, load_ready, Dout, dout_valid, last}
        vecs[0]  = '{1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'hD, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[24] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};

        applyStimulus(1'b0, 1'b0, 4'h0);
        m_lv = 1'b0; m_din = 4'h0;
        w_lv = 1'b0; w_din = 1'b0;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].clr, vecs[i].lv, vecs[i].din);
            #1;
            checkOutput($sformatf("vec%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].ready});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d dout", i),  {31'b0, dout},   {31'b0, vecs[i].dout});
            checkOutput($sformatf("vec%0d valid", i), {31'b0, dvalid}, {31'b0, vecs[i].valid});
            checkOutput($sformatf("vec%0d last", i),  {31'b0, dlast},  {31'b0, vecs[i].last});
            checkOutput($sformatf("vec%0d busy", i),  {31'b0, dbusy},  {31'b0, vecs[i].valid});
        end

        // Mid-word reset: abort 4'hF on its second bit without waiting for an edge.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'hF);
        @(posedge clk); #1;
        checkOutput("abort bit0", {31'b0, dout}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h0);
        @(posedge clk); #1;
        checkOutput("abort bit1 valid", {31'b0, dvalid}, 32'd1);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("abort dout",  {31'b0, dout},   32'd0);
        checkOutput("abort valid", {31'b0, dvalid}, 32'd0);
        checkOutput("abort last",  {31'b0, dlast},  32'd0);
        checkOutput("abort busy",  {31'b0, dbusy},  32'd0);
        checkOutput("abort ready", {31'b0, ready},  32'd0);
        checkOutput("msb reset dout",  {31'b0, m_dout},  32'd1);
        checkOutput("msb reset ready", {31'b0, m_ready}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'h3);
        exp3 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i == 0) checkOutput("post-abort ready", {31'b0, ready}, 32'd1);
            @(posedge clk); #1;
            checkOutput($sformatf("post-abort bit%0d", i), {31'b0, dout}, {31'b0, exp3[i]});
            checkOutput($sformatf("post-abort last%0d", i), {31'b0, dlast}, {31'b0, (i == 3)});
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 4'h0);
        end
        @(posedge clk); #1;
        checkOutput("post-abort idle", {31'b0, dvalid}, 32'd0);

        // Loopback into the right-shift receiver.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'hD);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("loopback q", {28'b0, q}, 32'hD);

        // MSB-first build with idle level 1.
        @(negedge clk);
        checkOutput("msb idle dout", {31'b0, m_dout}, 32'd1);
        m_lv = 1'b1; m_din = 4'h8;
        exp8 = 4'b1000;
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1;
            checkOutput($sformatf("msb bit%0d", i), {31'b0, m_dout}, {31'b0, exp8[i]});
            checkOutput($sformatf("msb last%0d", i), {31'b0, m_last}, {31'b0, (i == 0)});
            @(negedge clk);
            m_lv = 1'b0; m_din = 4'h0;
        end
        @(posedge clk); #1;
        checkOutput("msb end dout",  {31'b0, m_dout},  32'd1);
        checkOutput("msb end valid", {31'b0, m_valid}, 32'd0);

        // Single-bit words streamed back to back.
        w1bits = 3'b101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_lv = 1'b1; w_din = w1bits[i];
            #1;
            checkOutput($sformatf("w1 ready%0d", i), {31'b0, w_ready}, 32'd1);
            @(posedge clk); #1;
            checkOutput($sformatf("w1 dout%0d", i),  {31'b0, w_dout},  {31'b0, w1bits[i]});
            checkOutput($sformatf("w1 valid%0d", i), {31'b0, w_valid}, 32'd1);
            checkOutput($sformatf("w1 last%0d", i),  {31'b0, w_last},  32'd1);
        end
        @(negedge clk);
        w_lv = 1'b0;
        @(posedge clk); #1;
        checkOutput("w1 idle valid", {31'b0, w_valid}, 32'd0);
        checkOutput("w1 idle last",  {31'b0, w_last},  32'd0);
        checkOutput("w1 idle busy",  {31'b0, w_busy},  32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
